// File: rtl/ctrl_pkg.sv
// Shared types for the multi-cycle decode controller: FSM states, opcode
// constants and the instruction-format classification.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } ctrl_state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    CL_R,
    CL_I,
    CL_S,
    CL_B,
    CL_U,
    CL_J,
    CL_ILL
  } instr_class_e;

  function automatic instr_class_e classify(input logic [6:0] op);
    instr_class_e c;
    case (op)
      OP_R:                     c = CL_R;
      OP_IMM, OP_LOAD, OP_JALR: c = CL_I;
      OP_STORE:                 c = CL_S;
      OP_BRANCH:                c = CL_B;
      OP_LUI, OP_AUIPC:         c = CL_U;
      OP_JAL:                   c = CL_J;
      default:                  c = CL_ILL;
    endcase
    return c;
  endfunction

  // Bit order {r, i, s, b, u, j}; illegal opcodes map to all zero.
  function automatic logic [5:0] class_flags(input instr_class_e c);
    logic [5:0] f;
    case (c)
      CL_R:    f = 6'b100000;
      CL_I:    f = 6'b010000;
      CL_S:    f = 6'b001000;
      CL_B:    f = 6'b000100;
      CL_U:    f = 6'b000010;
      CL_J:    f = 6'b000001;
      default: f = 6'b000000;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/decode_ctrl_if.sv
// Fetch/memory handshake and datapath control bundle of the decode controller.
// instr is taken on a cycle where instr_valid && instr_ready; mem_done is only honoured while mem_req is high.
interface decode_ctrl_if #(
  parameter int RETIRE_W = 32
);
  import ctrl_pkg::*;

  logic                instr_valid;
  logic [31:0]         instr;
  logic                instr_ready;
  logic                mem_done;
  logic                flush;
  logic [31:0]         ir;
  logic                r_type;
  logic                i_type;
  logic                s_type;
  logic                b_type;
  logic                u_type;
  logic                j_type;
  logic                ir_we;
  logic                pc_we;
  logic                reg_we;
  logic                mem_req;
  logic                mem_we;
  logic                trap;
  logic [RETIRE_W-1:0] retired;
  ctrl_state_e         state;

  modport slave (
    input  instr_valid, instr, mem_done, flush,
    output instr_ready, ir, r_type, i_type, s_type, b_type, u_type, j_type,
           ir_we, pc_we, reg_we, mem_req, mem_we, trap, retired, state
  );

  modport master (
    output instr_valid, instr, mem_done, flush,
    input  instr_ready, ir, r_type, i_type, s_type, b_type, u_type, j_type,
           ir_we, pc_we, reg_we, mem_req, mem_we, trap, retired, state
  );

endinterface

// File: rtl/decode_ctrl.sv
// Multi-cycle instruction sequencer: latches the instruction, drives the
// decoder format flags and datapath strobes, and counts retired instructions.
module decode_ctrl
  import ctrl_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  decode_ctrl_if.slave  bus
);

  ctrl_state_e         state_q, state_d;
  logic [31:0]         ir_q, ir_d;
  logic [5:0]          flags_q, flags_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;

  instr_class_e cls;
  logic         is_load;
  logic         instr_ready, ir_we, pc_we, reg_we, mem_req, mem_we;

  assign cls     = classify(ir_q[6:0]);
  assign is_load = (ir_q[6:0] == OP_LOAD);

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    instr_ready = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    reg_we      = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;

    // flush wins over everything and silences every strobe for its cycle.
    if (bus.flush) begin
      state_d = ST_FETCH;
    end else begin
      case (state_q)
        ST_FETCH: begin
          instr_ready = 1'b1;
          if (bus.instr_valid) begin
            ir_we   = 1'b1;
            ir_d    = bus.instr;
            state_d = ST_DECODE;
          end
        end
        ST_DECODE: state_d = (cls == CL_ILL) ? ST_TRAP : ST_EXEC;
        ST_EXEC: begin
          if (is_load || cls == CL_S) begin
            state_d = ST_MEM;
          end else if (cls == CL_B) begin
            pc_we   = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
        ST_MEM: begin
          mem_req = 1'b1;
          mem_we  = (cls == CL_S);
          if (bus.mem_done) begin
            if (cls == CL_S) begin
              pc_we   = 1'b1;
              state_d = ST_FETCH;
            end else begin
              state_d = ST_WB;
            end
          end
        end
        ST_WB: begin
          reg_we  = 1'b1;
          pc_we   = 1'b1;
          state_d = ST_FETCH;
        end
        ST_TRAP: state_d = ST_TRAP;
        default: state_d = ST_FETCH;
      endcase
    end

    retired_d = retired_q + RETIRE_W'(pc_we);
    // Flags follow the instruction that will occupy the next state.
    flags_d = (state_d inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB})
              ? class_flags(classify(ir_d[6:0])) : 6'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      ir_q      <= '0;
      flags_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      flags_q   <= flags_d;
      retired_q <= retired_d;
    end
  end

  assign bus.instr_ready = instr_ready;
  assign bus.ir          = ir_q;
  assign {bus.r_type, bus.i_type, bus.s_type,
          bus.b_type, bus.u_type, bus.j_type} = flags_q;
  assign bus.ir_we       = ir_we;
  assign bus.pc_we       = pc_we;
  assign bus.reg_we      = reg_we;
  assign bus.mem_req     = mem_req;
  assign bus.mem_we      = mem_we;
  assign bus.trap        = (state_q == ST_TRAP);
  assign bus.retired     = retired_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_decode_ctrl.sv
// Bench for decode_ctrl: per-instruction cycle schedules built from the format
// rules feed an expected queue checked every cycle, plus literal spot checks.
module tb_decode_ctrl;

  logic clk;
  logic rst_n;

  decode_ctrl_if #(.RETIRE_W(32)) bus ();
  decode_ctrl_if #(.RETIRE_W(4))  bus4 ();

  decode_ctrl #(.RETIRE_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Narrow-counter twin sharing the same stimulus, used to reach the wrap point.
  decode_ctrl #(.RETIRE_W(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  assign bus4.instr_valid = bus.instr_valid;
  assign bus4.instr       = bus.instr;
  assign bus4.mem_done    = bus.mem_done;
  assign bus4.flush       = bus.flush;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- expected record ----------------
  typedef struct packed {
    logic        rdy;
    logic        ir_we;
    logic        pc_we;
    logic        reg_we;
    logic        mem_req;
    logic        mem_we;
    logic        trap;
    logic [5:0]  flags;
    logic [31:0] ir;
    logic [31:0] ret;
    logic [3:0]  ret4;
  } exp_t;

  localparam int EW = $bits(exp_t);
  localparam logic [5:0] S_RDY  = 6'b100000;
  localparam logic [5:0] S_IRWE = 6'b010000;
  localparam logic [5:0] S_PC   = 6'b001000;
  localparam logic [5:0] S_REG  = 6'b000100;
  localparam logic [5:0] S_REQ  = 6'b000010;
  localparam logic [5:0] S_WE   = 6'b000001;

  logic [EW-1:0] exp_q[$];
  string         tag_q[$];
  int            n_cmp = 0;
  int            n_err = 0;

  // Architectural view kept by the model
  logic [31:0] m_ir;
  logic [31:0] m_ret;

  // Run-control of the current instruction schedule
  logic [31:0] cur_w;
  int          idx;
  int          cut_i;
  int          cut_k;
  logic        abort;

  // Format flags {r,i,s,b,u,j} straight from the opcode table
  function automatic logic [5:0] fmt_flags(input logic [31:0] w);
    logic [5:0] f;
    case (w[6:0])
      7'h33:               f = 6'b100000;
      7'h13, 7'h03, 7'h67: f = 6'b010000;
      7'h23:               f = 6'b001000;
      7'h63:               f = 6'b000100;
      7'h37, 7'h17:        f = 6'b000010;
      7'h6f:               f = 6'b000001;
      default:             f = 6'b000000;
    endcase
    return f;
  endfunction

  function automatic exp_t mk(input logic [5:0] s, input logic [5:0] f, input logic tr);
    exp_t e;
    {e.rdy, e.ir_we, e.pc_we, e.reg_we, e.mem_req, e.mem_we} = s;
    e.trap  = tr;
    e.flags = f;
    e.ir    = m_ir;
    e.ret   = m_ret;
    e.ret4  = m_ret[3:0];
    return e;
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    exp_t  e;
    exp_t  a;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a.rdy     = bus.instr_ready;
      a.ir_we   = bus.ir_we;
      a.pc_we   = bus.pc_we;
      a.reg_we  = bus.reg_we;
      a.mem_req = bus.mem_req;
      a.mem_we  = bus.mem_we;
      a.trap    = bus.trap;
      a.flags   = {bus.r_type, bus.i_type, bus.s_type, bus.b_type, bus.u_type, bus.j_type};
      a.ir      = bus.ir;
      a.ret     = bus.retired;
      a.ret4    = bus4.retired;
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL cycle %s @%0t: got %h want %h (rdy,irwe,pcwe,regwe,req,we,trap,flags,ir,ret,ret4)",
                 t, $time, a, e);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_cycle(input logic v, input logic [31:0] w, input logic md,
                             input logic fl, input exp_t e, input string tag);
    bus.instr_valid = v;
    bus.instr       = w;
    bus.mem_done    = md;
    bus.flush       = fl;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.instr_valid = 1'b0;
    bus.flush       = 1'b0;
    bus.mem_done    = 1'b0;
    #1;
  endtask

  task automatic idle();
    drive_cycle(1'b0, $urandom, 1'b0, 1'b0, mk(S_RDY, 6'b0, 1'b0), "idle");
  endtask

  // One cycle of an instruction schedule; a flush cut silences strobes and ends it.
  task automatic emit(input logic fetch, input logic md, input exp_t e, input string tag);
    logic fl;
    if (abort) return;
    if (idx == cut_i && cut_k == 2) begin
      abort = 1'b1;
      return;
    end
    fl = (idx == cut_i) && (cut_k == 1);
    if (fl) begin
      e.rdy = 1'b0; e.ir_we = 1'b0; e.pc_we = 1'b0;
      e.reg_we = 1'b0; e.mem_req = 1'b0; e.mem_we = 1'b0;
    end
    drive_cycle(fetch ? 1'b1 : 1'($urandom_range(0, 1)), fetch ? cur_w : $urandom,
                md, fl, e, fl ? {tag, "_flush"} : tag);
    idx++;
    if (fl) abort = 1'b1;
    else begin
      if (e.ir_we) m_ir = cur_w;
      if (e.pc_we) m_ret = m_ret + 32'd1;
    end
  endtask

  // cut_kind: 0 none, 1 flush at cycle cut_at, 2 stop before cycle cut_at
  task automatic run_instr(input logic [31:0] w, input int n_mem, input int cut_at,
                           input int cut_kind, output int len);
    logic [5:0] f;
    logic       ld, st;
    f = fmt_flags(w);
    ld = (w[6:0] == 7'h03);
    st = (f == 6'b001000);
    cur_w = w; idx = 0; abort = 1'b0; cut_i = cut_at; cut_k = cut_kind;
    emit(1'b1, 1'b0, mk(S_RDY | S_IRWE, 6'b0, 1'b0), "accept");
    emit(1'b0, 1'($urandom_range(0, 1)), mk(6'b0, f, 1'b0), "decode");
    if (f != 6'b0) begin
      if (f == 6'b000100) begin
        emit(1'b0, 1'($urandom_range(0, 1)), mk(S_PC, f, 1'b0), "exec_b");
      end else begin
        emit(1'b0, 1'($urandom_range(0, 1)), mk(6'b0, f, 1'b0), "exec");
        if (ld || st) begin
          for (int i = 1; i <= n_mem; i++)
            emit(1'b0, (i == n_mem), mk(S_REQ | (st ? S_WE : 6'b0) | ((st && i == n_mem) ? S_PC : 6'b0),
                                         f, 1'b0), "mem");
        end
        if (!st) emit(1'b0, 1'b0, mk(S_PC | S_REG, f, 1'b0), "wb");
      end
    end
    len = idx;
  endtask

  logic [31:0] tbl [14] = '{
    32'h00220433, 32'h00108093, 32'h000012b7, 32'h00001317, 32'h000080e7,
    32'h00330263, 32'hFE330E23, 32'h00002503, 32'h40208033, 32'h00a00513,
    32'h00112623, 32'h0081a403, 32'hfe0098e3, 32'h12345037
  };

  // ---------------- main sequence ----------------
  initial begin
    int len;
    rst_n = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.mem_done    = 1'b0;
    bus.flush       = 1'b0;
    m_ir  = '0;
    m_ret = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    quiet();
    chk("rst_ready", 32'(bus.instr_ready), 32'd1);
    chk("rst_retired", bus.retired, 32'd0);
    chk("rst_ir", bus.ir, 32'd0);
    chk("rst_trap_flags", {25'd0, bus.trap, bus.r_type, bus.i_type, bus.s_type,
                           bus.b_type, bus.u_type, bus.j_type}, 32'd0);
    idle();
    idle();

    run_instr(32'h00220433, 0, -1, 0, len);
    chk("r_len", len, 32'd4);
    chk("r_retired", bus.retired, 32'd1);

    run_instr(32'hFE330E23, 3, -1, 0, len);
    chk("s_len", len, 32'd6);
    chk("s_retired", bus.retired, 32'd2);

    run_instr(32'h00330263, 0, -1, 0, len);
    chk("b_len", len, 32'd3);
    chk("b_retired", bus.retired, 32'd3);

    run_instr(32'h00000073, 0, -1, 0, len);
    for (int i = 0; i < 10; i++)
      drive_cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0,
                  mk(6'b0, 6'b0, 1'b1), "trap_hold");
    chk("trap_held", 32'(bus.trap), 32'd1);
    chk("trap_retired", bus.retired, 32'd3);
    drive_cycle(1'b1, $urandom, 1'b0, 1'b1, mk(6'b0, 6'b0, 1'b1), "trap_flush");
    quiet();
    chk("trap_cleared", 32'(bus.trap), 32'd0);
    idle();

    run_instr(32'h00220433, 0, 0, 1, len);
    idle();
    run_instr(32'h00220433, 0, 2, 1, len);
    idle();
    run_instr(32'h00220433, 0, 3, 1, len);
    idle();
    run_instr(32'hFE330E23, 2, 4, 1, len);
    idle();
    run_instr(32'h00000073, 0, 1, 1, len);
    idle();
    chk("flush_retired", bus.retired, 32'd3);
    chk("flush_ir", bus.ir, 32'h00000073);

    run_instr(32'h00002503, 3, 4, 2, len);
    rst_n = 1'b0;
    bus.instr_valid = 1'b0;
    bus.mem_done    = 1'b0;
    bus.flush       = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_ir  = '0;
    m_ret = '0;
    quiet();
    chk("rstmem_req", 32'(bus.mem_req), 32'd0);
    chk("rstmem_ready", 32'(bus.instr_ready), 32'd1);
    chk("rstmem_retired", bus.retired, 32'd0);
    chk("rstmem_ir", bus.ir, 32'd0);
    idle();

    run_instr(32'h00002503, 2, -1, 0, len);
    chk("ld_len", len, 32'd6);
    for (int i = 0; i < 14; i++)
      run_instr(tbl[i], $urandom_range(1, 3), -1, 0, len);
    chk("pre_wrap4", 32'(bus4.retired), 32'd15);
    run_instr(32'h0000156F, 0, -1, 0, len);
    chk("j_len", len, 32'd4);
    chk("wrap4_retired", 32'(bus4.retired), 32'd0);
    chk("j_retired", bus.retired, 32'd16);
    idle();
    idle();

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decode_ctrl.md
DECODE_CTRL -- requirements
Module: decode_ctrl

Interface
REQ-001 Parameter RETIRE_W, default 32, width of the retired-instruction counter.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 instr_valid  input  1  fetch side offers an instruction this cycle.
REQ-005 instr  input  32  offered instruction word.
REQ-006 instr_ready  output  1  controller accepts instr this cycle.
REQ-007 mem_done  input  1  data memory finished the current access.
REQ-008 flush  input  1  abandon current instruction, return to FETCH.
REQ-009 ir  output  32  latched instruction, feeds the decoder's instr input.
REQ-010 r_type, i_type, s_type, b_type, u_type, j_type  output  1 each  one-hot format flags to the decoder.
REQ-011 ir_we, pc_we, reg_we, mem_req, mem_we  output  1 each  datapath strobes.
REQ-012 trap  output  1  illegal opcode detected.
REQ-013 retired  output  RETIRE_W  count of completed instructions.

Function
REQ-014 FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB, TRAP.
REQ-015 FETCH: instr_ready=1; on instr_valid, ir<=instr, ir_we=1, go DECODE; else stay.
REQ-016 Opcode classes (ir[6:0]): 0110011 R; 0010011/0000011/1100111 I; 0100011 S; 1100011 B; 0110111/0010111 U; 1101111 J; all others illegal.
REQ-017 Type flags SHALL be registered, asserted one-hot from DECODE through the last state of the instruction, all zero in FETCH and TRAP.
REQ-018 DECODE: one cycle; illegal -> TRAP; else -> EXEC.
REQ-019 EXEC: one cycle; load (0000011) or S -> MEM; B -> FETCH with pc_we=1; all other classes -> WB.
REQ-020 MEM: mem_req=1 held every cycle until mem_done; mem_we=1 for S only; on mem_done, load -> WB, store -> FETCH with pc_we=1.
REQ-021 mem_done outside MEM SHALL be ignored.
REQ-022 WB: reg_we=1, pc_we=1, one cycle, -> FETCH.
REQ-023 retired SHALL increment by 1 on every cycle pc_we=1, wrapping from all-ones to 0.
REQ-024 Cycles per instruction, accept cycle to next FETCH inclusive: R/I(non-load)/U/J 4; B 3; store 3+N, load 4+N, N = MEM cycles (min 1).
REQ-025 TRAP: trap=1 held, no strobes, no counting; exit only via flush or reset.
REQ-026 flush in any state SHALL force FETCH next cycle, suppress all strobes that cycle, leave ir and retired unchanged; flush has priority over every other transition.
REQ-027 flush with instr_valid in FETCH: instruction not accepted that cycle.
REQ-028 Strobes SHALL be combinational from state and latched ir only, never from instr.

Reset
REQ-029 With rst_n=0 at a rising edge: state=FETCH, ir=0, type flags=0, retired=0, trap=0, all strobes 0 except instr_ready=1 in the following cycle.
REQ-030 Reset mid-instruction (any state, including MEM with mem_req high) SHALL abandon it without retiring.

Structure
REQ-031 Shared package ctrl_pkg SHALL hold the state enum, opcode constants, and an instr-class enum with classification function.
REQ-032 No sub-module; the decoder is instantiated alongside by the parent stage, driven by ir and the type flags.

Verification
REQ-033 Accept 0x00220433 -> r_type=1 in DECODE..WB, reg_we and pc_we in cycle 4, retired 0->1.
REQ-034 Accept 0xFE330E23, mem_done after 3 MEM cycles -> s_type=1, mem_req=mem_we=1 for 3 cycles, pc_we=1 on third, reg_we never 1.
REQ-035 Accept 0x00330263 -> b_type=1, FETCH again after 3 cycles, no mem_req, no reg_we, retired +1.
REQ-036 Accept 0x00000073 -> trap=1 from cycle 3, held 10 cycles with retired unchanged; flush -> FETCH, trap=0.
REQ-037 Accept 0x00002503 (load), rst_n=0 during MEM -> next cycle FETCH, mem_req=0, retired=0, ir=0.
REQ-038 Preload retired=0xFFFFFFFF via 2^32-1 retirements or forced state, retire 0x0000156F -> j_type=1, retired=0.
